// File: rtl/gearbox_pkg.sv
// Shared types and grant-length helper for the gearbox pair arbiter.
package gearbox_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } gb_arb_state_t;

  // The downstream gearbox merges two narrow beats into one wide word.
  localparam int BEATS_PER_PAIR = 2;

  function automatic int grant_beats(input int pairs);
    return pairs * BEATS_PER_PAIR;
  endfunction

endpackage

// File: rtl/gearbox_pair_arbiter.sv
// Round-robin arbiter sharing one 2x upsizing gearbox input between two
// AXI-Stream requesters; grants are locked for whole beat pairs.
module gearbox_pair_arbiter
  import gearbox_pkg::*;
#(
  parameter int n     = 5,
  parameter int nb    = n * 8,
  parameter int PAIRS = 4,
  parameter int CW    = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [nb-1:0] s0_tdata,
  input  logic          s0_tvalid,
  output logic          s0_tready,
  input  logic [nb-1:0] s1_tdata,
  input  logic          s1_tvalid,
  output logic          s1_tready,
  output logic [nb-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tid,
  output logic          m_tlast,
  output logic [CW-1:0] pairs0,
  output logic [CW-1:0] pairs1
);

  localparam int BEATS = grant_beats(PAIRS);
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // Handshake: a beat transfers on a cycle where valid and ready are both
  // high; valid never waits on ready, ready is passed straight from m_tready
  // to the current owner only.

  gb_arb_state_t state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CW-1:0] pairs0_q, pairs0_d;
  logic [CW-1:0] pairs1_q, pairs1_d;
  logic          beat_hs;

  function automatic logic pick_grant(input logic v0, input logic v1,
                                      input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    pairs0_d     = pairs0_q;
    pairs1_d     = pairs1_q;
    m_tdata      = '0;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
    s0_tready    = 1'b0;
    s1_tready    = 1'b0;
    beat_hs      = 1'b0;

    if (state_q == ST_IDLE) begin
      // The grant is registered here, so IDLE never forwards data.
      if (s0_tvalid || s1_tvalid) begin
        grant_d = pick_grant(s0_tvalid, s1_tvalid, last_grant_q);
        state_d = ST_BUSY;
      end
    end else begin
      m_tdata   = grant_q ? s1_tdata : s0_tdata;
      m_tvalid  = grant_q ? s1_tvalid : s0_tvalid;
      s0_tready = ~grant_q & m_tready;
      s1_tready = grant_q & m_tready;
      m_tlast   = (beat_cnt_q == LAST_BEAT);
      beat_hs   = m_tvalid & m_tready;

      if (beat_hs) begin
        // An odd beat closes a pair in the gearbox.
        if (beat_cnt_q[0]) begin
          if (grant_q) pairs1_d = pairs1_q + CW'(1);
          else         pairs0_d = pairs0_q + CW'(1);
        end
        if (beat_cnt_q == LAST_BEAT) begin
          beat_cnt_d   = '0;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      pairs0_q     <= '0;
      pairs1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      pairs0_q     <= pairs0_d;
      pairs1_q     <= pairs1_d;
    end
  end

  assign m_tid  = grant_q;
  assign pairs0 = pairs0_q;
  assign pairs1 = pairs1_q;

endmodule

// File: tb/tb_gearbox_pair_arbiter.sv
// Self-checking bench for gearbox_pair_arbiter: randomized sources and ready,
// checked against a stream-level model of grants, pairs and data order.
module tb_gearbox_pair_arbiter;

  localparam int N     = 5;
  localparam int NB    = N * 8;
  localparam int PAIRS = 4;
  localparam int CW    = 4;
  localparam int BEATS = 2 * PAIRS;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [NB-1:0] s0_tdata, s1_tdata, m_tdata;
  logic          s0_tvalid, s1_tvalid, s0_tready, s1_tready;
  logic          m_tvalid, m_tready, m_tid, m_tlast;
  logic [CW-1:0] pairs0, pairs1;

  int total = 0;
  int bad   = 0;

  int src_mode[2];   // 0 off, 1 always valid, 2 random valid
  int rdy_mode;      // 0 always ready, 1 toggle, 2 random
  int cyc = 0;
  logic hs0_s, hs1_s;

  logic [NB-1:0] exp_q0[$];
  logic [NB-1:0] exp_q1[$];
  int            seg_pos;
  logic          seg_tid;
  int            exp_pairs[2];
  bit            bubble_exp;
  bit            prev_stall;
  logic [NB-1:0] prev_data;
  logic          prev_tid, prev_last;
  int            m_beats;
  int            hs_cyc[$];
  logic          grant_log[$];

  gearbox_pair_arbiter #(.n(N), .nb(NB), .PAIRS(PAIRS), .CW(CW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tid(m_tid), .m_tlast(m_tlast), .pairs0(pairs0), .pairs1(pairs1)
  );

  always #5 aclk = ~aclk;

  task automatic model_clear();
    seg_pos      = 0;
    seg_tid      = 1'b0;
    exp_pairs[0] = 0;
    exp_pairs[1] = 0;
    bubble_exp   = 1'b0;
    prev_stall   = 1'b0;
    m_beats      = 0;
    exp_q0.delete();
    exp_q1.delete();
    hs_cyc.delete();
    grant_log.delete();
  endtask

  // Stream-level checks, run once per cycle at the falling edge.
  task automatic monitor_cycle();
    logic [NB-1:0] want;
    total++;
    if (pairs0 !== CW'(exp_pairs[0]) || pairs1 !== CW'(exp_pairs[1])) begin
      bad++;
      $display("FAIL pairs_count got=%0d/%0d want=%0d/%0d", pairs0, pairs1,
               exp_pairs[0], exp_pairs[1]);
    end
    if (bubble_exp) begin
      total++;
      if (m_tvalid !== 1'b0 || s0_tready !== 1'b0 || s1_tready !== 1'b0) begin
        bad++;
        $display("FAIL idle_bubble got valid=%b rdy=%b%b want 0 00", m_tvalid,
                 s0_tready, s1_tready);
      end
    end
    if (prev_stall) begin
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tid !== prev_tid ||
          m_tlast !== prev_last) begin
        bad++;
        $display("FAIL stall_hold got v=%b d=%h id=%b l=%b want v=1 d=%h id=%b l=%b",
                 m_tvalid, m_tdata, m_tid, m_tlast, prev_data, prev_tid, prev_last);
      end
    end
    total++;
    if ((s0_tready & m_tid) || (s1_tready & ~m_tid) ||
        ((s0_tready | s1_tready) & ~m_tready)) begin
      bad++;
      $display("FAIL ready_route got rdy=%b%b tid=%b m_tready=%b", s1_tready,
               s0_tready, m_tid, m_tready);
    end
    if (m_tvalid) begin
      total++;
      if (m_tdata !== (m_tid ? s1_tdata : s0_tdata) ||
          (m_tid ? s1_tvalid : s0_tvalid) !== 1'b1) begin
        bad++;
        $display("FAIL data_route got d=%h tid=%b want d=%h", m_tdata, m_tid,
                 m_tid ? s1_tdata : s0_tdata);
      end
    end
    if (hs0_s) exp_q0.push_back(s0_tdata);
    if (hs1_s) exp_q1.push_back(s1_tdata);
    if (m_tvalid && m_tready) begin
      m_beats++;
      hs_cyc.push_back(cyc);
      if (seg_pos == 0) begin
        seg_tid = m_tid;
        grant_log.push_back(m_tid);
      end else begin
        total++;
        if (m_tid !== seg_tid) begin
          bad++;
          $display("FAIL grant_tid got=%b want=%b beat=%0d", m_tid, seg_tid, seg_pos);
        end
      end
      total++;
      if (m_tlast !== (seg_pos == BEATS - 1)) begin
        bad++;
        $display("FAIL tlast got=%b want=%b beat=%0d", m_tlast,
                 (seg_pos == BEATS - 1), seg_pos);
      end
      want = '0;
      total++;
      if ((m_tid ? exp_q1.size() : exp_q0.size()) == 0) begin
        bad++;
        $display("FAIL data_order got=%h want=<none accepted from req%0d>", m_tdata, m_tid);
      end else begin
        want = m_tid ? exp_q1.pop_front() : exp_q0.pop_front();
        if (m_tdata !== want) begin
          bad++;
          $display("FAIL data_order got=%h want=%h", m_tdata, want);
        end
      end
      if (seg_pos % 2 == 1)
        exp_pairs[m_tid] = (exp_pairs[m_tid] + 1) % (1 << CW);
      bubble_exp = (seg_pos == BEATS - 1);
      seg_pos    = (seg_pos + 1) % BEATS;
    end else begin
      bubble_exp = 1'b0;
    end
    prev_stall = m_tvalid & ~m_tready;
    prev_data  = m_tdata;
    prev_tid   = m_tid;
    prev_last  = m_tlast;
  endtask

  // Sources hold valid and data until accepted, as AXI-Stream requires.
  task automatic drive_cycle();
    if (hs0_s) begin
      s0_tdata  = {8'd0, 32'($urandom)};
      s0_tvalid = (src_mode[0] == 1) || (src_mode[0] == 2 && $urandom_range(0, 1) == 1);
    end else if (src_mode[0] == 0) begin
      s0_tvalid = 1'b0;
    end else if (!s0_tvalid) begin
      s0_tvalid = (src_mode[0] == 1) || $urandom_range(0, 1) == 1;
    end
    if (hs1_s) begin
      s1_tdata  = {8'd1, 32'($urandom)};
      s1_tvalid = (src_mode[1] == 1) || (src_mode[1] == 2 && $urandom_range(0, 1) == 1);
    end else if (src_mode[1] == 0) begin
      s1_tvalid = 1'b0;
    end else if (!s1_tvalid) begin
      s1_tvalid = (src_mode[1] == 1) || $urandom_range(0, 1) == 1;
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = $urandom_range(0, 1) == 1;
    endcase
  endtask

  initial begin
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    s0_tdata  = {8'd0, 32'($urandom)};
    s1_tdata  = {8'd1, 32'($urandom)};
    m_tready  = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      hs0_s = aresetn & s0_tvalid & s0_tready;
      hs1_s = aresetn & s1_tvalid & s1_tready;
      if (aresetn) monitor_cycle();
      @(posedge aclk);
      #1;
      drive_cycle();
    end
  end

  task automatic apply_reset(input int cycles);
    @(posedge aclk);
    #1 aresetn = 1'b0;
    repeat (cycles) @(posedge aclk);
    #1 aresetn = 1'b1;
    model_clear();
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (m_beats < n && k < budget) begin
      @(negedge aclk);
      #1;
      k++;
    end
    total++;
    if (m_beats < n) begin
      bad++;
      $display("FAIL %s_timeout got beats=%0d want=%0d", tag, m_beats, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (m_tvalid !== 1'b0 || s0_tready !== 1'b0 || s1_tready !== 1'b0 ||
        m_tid !== 1'b0 || m_tlast !== 1'b0 || pairs0 !== '0 || pairs1 !== '0) begin
      bad++;
      $display("FAIL %s got v=%b rdy=%b%b id=%b l=%b p=%0d/%0d want all zero", tag,
               m_tvalid, s1_tready, s0_tready, m_tid, m_tlast, pairs0, pairs1);
    end
  endtask

  task automatic test_reset();
    src_mode[0] = 0;
    src_mode[1] = 0;
    rdy_mode    = 0;
    aresetn     = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    #1 check_reset_outputs("reset_values");
  endtask

  task automatic test_first_grant();
    src_mode[0] = 1;
    src_mode[1] = 1;
    rdy_mode    = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    model_clear();
    wait_beats(3 * BEATS, 100, "first_grant");
    total++;
    if (grant_log.size() < 3 || grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1 ||
        grant_log[2] !== 1'b0) begin
      bad++;
      $display("FAIL rr_order got n=%0d first=%b want 0,1,0", grant_log.size(),
               grant_log.size() > 0 ? grant_log[0] : 1'bx);
    end
    total++;
    if (hs_cyc.size() < BEATS + 1 || hs_cyc[BEATS-1] - hs_cyc[0] != BEATS - 1 ||
        hs_cyc[BEATS] - hs_cyc[BEATS-1] != 2) begin
      bad++;
      $display("FAIL throughput got span=%0d gap=%0d want %0d and 2",
               hs_cyc.size() > BEATS ? hs_cyc[BEATS-1] - hs_cyc[0] : -1,
               hs_cyc.size() > BEATS ? hs_cyc[BEATS] - hs_cyc[BEATS-1] : -1, BEATS - 1);
    end
  endtask

  task automatic test_single_s1();
    src_mode[0] = 0;
    src_mode[1] = 1;
    rdy_mode    = 0;
    apply_reset(1);
    wait_beats(2 * BEATS, 100, "single_s1");
    src_mode[1] = 0;
    repeat (4) @(negedge aclk);
    #1;
    total++;
    if (grant_log.size() != 2 || grant_log[0] !== 1'b1 || grant_log[1] !== 1'b1) begin
      bad++;
      $display("FAIL single_s1_grants got n=%0d want 2 grants to req1", grant_log.size());
    end
    total++;
    if (pairs1 !== CW'(8) || pairs0 !== '0) begin
      bad++;
      $display("FAIL single_s1_pairs got=%0d/%0d want 0/8", pairs0, pairs1);
    end
    total++;
    if (hs_cyc.size() < BEATS + 1 || hs_cyc[BEATS] - hs_cyc[BEATS-1] != 2) begin
      bad++;
      $display("FAIL single_s1_bubble got gap=%0d want 2",
               hs_cyc.size() > BEATS ? hs_cyc[BEATS] - hs_cyc[BEATS-1] : -1);
    end
  endtask

  task automatic test_valid_drop();
    src_mode[0] = 0;
    src_mode[1] = 1;
    rdy_mode    = 0;
    apply_reset(1);
    wait_beats(3, 50, "drop_start");
    src_mode[1] = 0;
    src_mode[0] = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      #1;
      total++;
      if (s0_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tid !== 1'b1) begin
        bad++;
        $display("FAIL drop_hold got s0_tready=%b m_tvalid=%b tid=%b want 0 0 1",
                 s0_tready, m_tvalid, m_tid);
      end
    end
    total++;
    if (m_beats != 3) begin
      bad++;
      $display("FAIL drop_beats got=%0d want=3", m_beats);
    end
    src_mode[1] = 1;
    wait_beats(BEATS + 1, 50, "drop_resume");
    total++;
    if (grant_log.size() < 2 || grant_log[0] !== 1'b1 || grant_log[1] !== 1'b0) begin
      bad++;
      $display("FAIL drop_next_grant got n=%0d want req1 then req0", grant_log.size());
    end
  endtask

  task automatic test_ready_toggle();
    src_mode[0] = 1;
    src_mode[1] = 0;
    rdy_mode    = 1;
    apply_reset(1);
    wait_beats(BEATS, 60, "toggle");
    total++;
    if (hs_cyc.size() < BEATS || hs_cyc[BEATS-1] - hs_cyc[0] != 2 * (BEATS - 1) ||
        seg_pos != 0 || grant_log.size() != 1) begin
      bad++;
      $display("FAIL toggle_span got span=%0d pos=%0d want %0d 0",
               hs_cyc.size() >= BEATS ? hs_cyc[BEATS-1] - hs_cyc[0] : -1, seg_pos,
               2 * (BEATS - 1));
    end
  endtask

  task automatic test_reset_mid();
    src_mode[0] = 0;
    src_mode[1] = 1;
    rdy_mode    = 0;
    apply_reset(1);
    wait_beats(5, 50, "mid_start");
    src_mode[0] = 1;
    @(posedge aclk);
    #1 aresetn = 1'b0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    model_clear();
    @(negedge aclk);
    #1 check_reset_outputs("mid_reset_values");
    wait_beats(1, 20, "mid_regrant");
    total++;
    if (grant_log.size() < 1 || grant_log[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_regrant got n=%0d want first grant req0", grant_log.size());
    end
  endtask

  task automatic test_wrap();
    src_mode[0] = 2;
    src_mode[1] = 0;
    rdy_mode    = 2;
    apply_reset(1);
    wait_beats(40, 800, "wrap");
    src_mode[0] = 0;
    repeat (4) @(negedge aclk);
    #1;
    total++;
    if (pairs0 !== CW'(4) || pairs1 !== '0 || grant_log.size() != 5) begin
      bad++;
      $display("FAIL wrap got pairs0=%0d pairs1=%0d grants=%0d want 4 0 5",
               pairs0, pairs1, grant_log.size());
    end
  endtask

  task automatic test_random();
    src_mode[0] = 2;
    src_mode[1] = 2;
    rdy_mode    = 2;
    apply_reset(1);
    repeat (400) @(negedge aclk);
    #1;
    total++;
    if (m_beats < BEATS || exp_q0.size() != 0 || exp_q1.size() != 0) begin
      bad++;
      $display("FAIL random_flow got beats=%0d pending=%0d/%0d want >=%0d 0/0",
               m_beats, exp_q0.size(), exp_q1.size(), BEATS);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_first_grant();
    test_single_s1();
    test_valid_drop();
    test_ready_toggle();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
